// File: rtl/cfg_reg_bank.sv
// Parametrised configuration register bank with RW, RO and W1C register kinds.
// One request at a time: IDLE accepts, WAIT inserts wait states, ACK completes.
module cfg_reg_bank #(
    parameter int                   ADDR_W      = 8,
    parameter int                   REG_W       = 8,
    parameter int                   NUM_REGS    = 8,
    parameter int                   WAIT_CYCLES = 0,
    parameter logic [NUM_REGS-1:0]  RO_MASK     = '0,
    parameter logic [NUM_REGS-1:0]  W1C_MASK    = '0,
    parameter logic [REG_W-1:0]     RESET_VAL   = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ena,
    input  logic                      wr_rdn,
    input  logic [ADDR_W-1:0]         addr,
    input  logic [REG_W-1:0]          wdata,
    input  logic                      we,
    output logic [REG_W-1:0]          rdata,
    output logic                      ack,
    output logic                      err,
    input  logic [NUM_REGS*REG_W-1:0] status_in,
    input  logic [NUM_REGS*REG_W-1:0] set_in,
    output logic [NUM_REGS*REG_W-1:0] reg_out,
    output logic                      irq
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_t;

    localparam logic [3:0]      CNT_INIT   = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam logic [ADDR_W:0] NUM_REGS_X = (ADDR_W + 1)'(NUM_REGS);

    state_t              state;
    state_t              state_nxt;
    logic [3:0]          cnt;
    logic [3:0]          cnt_nxt;
    logic                accept;

    logic                wr_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [REG_W-1:0]    wdata_q;

    logic                view_wr;
    logic [ADDR_W-1:0]   view_addr;
    logic                in_range;
    logic                sel_ro;
    logic [REG_W-1:0]    sel_val;
    logic                req_err;
    logic                commit;
    logic [NUM_REGS-1:0] wr_hit;
    logic [NUM_REGS-1:0] w1c_any;
    logic                unused_inputs;

    assign accept = (state == S_IDLE) && ena && we;

    // ------------------------------------------------------------------
    // Control FSM: state register and request capture
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                wr_q    <= wr_rdn;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can infer a latch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (WAIT_CYCLES > 0) begin
                        state_nxt = S_WAIT;
                        cnt_nxt   = CNT_INIT;
                    end else begin
                        state_nxt = S_ACK;
                    end
                end
            end
            S_WAIT: begin
                if (!ena) begin
                    state_nxt = S_IDLE;
                end else if (cnt == 4'd0) begin
                    state_nxt = S_ACK;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            S_ACK: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Address decode. With zero wait states ACK is entered on the accept
    // edge, before the capture registers load, so decode the live request
    // while idle and the captured one otherwise.
    // ------------------------------------------------------------------
    always_comb begin
        view_wr   = (state == S_IDLE) ? wr_rdn : wr_q;
        view_addr = (state == S_IDLE) ? addr   : addr_q;
        in_range  = {1'b0, view_addr} < NUM_REGS_X;
        sel_ro    = 1'b0;
        sel_val   = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (view_addr == ADDR_W'(i)) begin
                sel_ro  = RO_MASK[i];
                sel_val = reg_out[i*REG_W +: REG_W];
            end
        end
        req_err = !in_range || (view_wr && sel_ro);
    end

    always_comb begin
        ack    = (state == S_ACK);
        err    = ack && req_err;
        commit = ack && ena && wr_q && !req_err;
        wr_hit = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            wr_hit[i] = commit && (addr_q == ADDR_W'(i));
        end
    end

    // Read data is captured on the edge entering ACK and held until the next read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if ((state_nxt == S_ACK) && !view_wr) begin
            rdata <= req_err ? '0 : sel_val;
        end
    end

    // ------------------------------------------------------------------
    // Register storage, one generate slot per register kind
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        if (RO_MASK[i]) begin : g_ro
            assign reg_out[i*REG_W +: REG_W] = status_in[i*REG_W +: REG_W];
            assign w1c_any[i]                = 1'b0;
        end else if (W1C_MASK[i]) begin : g_w1c
            logic [REG_W-1:0] q;
            // NOTE: each register is a discrete flop bank, not a memory, so it
            // can take an asynchronous reset without blocking RAM inference.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    q <= '0;
                end else if (wr_hit[i]) begin
                    // Set is ORed in after the clear, so a same-cycle set wins.
                    q <= (q & ~wdata_q) | set_in[i*REG_W +: REG_W];
                end else begin
                    q <= q | set_in[i*REG_W +: REG_W];
                end
            end
            assign reg_out[i*REG_W +: REG_W] = q;
            assign w1c_any[i]                = |q;
        end else begin : g_rw
            logic [REG_W-1:0] q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    q <= RESET_VAL;
                end else if (wr_hit[i]) begin
                    q <= wdata_q;
                end
            end
            assign reg_out[i*REG_W +: REG_W] = q;
            assign w1c_any[i]                = 1'b0;
        end
    end

    assign irq = |w1c_any;

    // Slices of status_in/set_in belonging to other register kinds are ignored.
    assign unused_inputs = ^{status_in, set_in};

endmodule

// File: tb/tb_cfg_reg_bank.sv
// Directed bench for cfg_reg_bank: expected ack results are queued at request
// time and popped when the ack pulse is seen.
module tb_cfg_reg_bank;

    localparam int ADDR_W = 8;
    localparam int REG_W  = 8;
    localparam int NR     = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             ena;
    logic             wr_rdn;
    logic [7:0]       addr;
    logic [7:0]       wdata;
    logic             we;
    logic [7:0]       rdata;
    logic             ack;
    logic             err;
    logic [NR*8-1:0]  status_in;
    logic [NR*8-1:0]  set_in;
    logic [NR*8-1:0]  reg_out;
    logic             irq;

    int tests = 0;
    int fails = 0;

    logic [8:0] sb[$];          // {rdata, err}
    logic [7:0] m_rw [0:4];     // model of RW registers 0..4
    logic [7:0] m_w1c;          // model of W1C register 5

    cfg_reg_bank #(
        .ADDR_W     (ADDR_W),
        .REG_W      (REG_W),
        .NUM_REGS   (NR),
        .WAIT_CYCLES(2),
        .RO_MASK    (8'hC0),
        .W1C_MASK   (8'h20),
        .RESET_VAL  (8'h5A)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .wr_rdn   (wr_rdn),
        .addr     (addr),
        .wdata    (wdata),
        .we       (we),
        .rdata    (rdata),
        .ack      (ack),
        .err      (err),
        .status_in(status_in),
        .set_in   (set_in),
        .reg_out  (reg_out),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    function automatic logic [NR*8-1:0] exp_out();
        logic [NR*8-1:0] v;
        for (int i = 0; i < 5; i++) v[i*8 +: 8] = m_rw[i];
        v[5*8 +: 8] = m_w1c;
        v[6*8 +: 16] = status_in[6*8 +: 16];
        return v;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request, expect ack exactly 3 cycles after acceptance.
    task automatic req(input string tag, input logic wr, input logic [7:0] a, input logic [7:0] d,
                       input logic [7:0] exp_rd, input logic exp_err,
                       input logic [7:0] set_at_ack, input logic drop_ena);
        logic [8:0] e;
        int lat;
        lat = 0;
        @(negedge clk);
        wr_rdn = wr; addr = a; wdata = d; we = 1'b1;
        sb.push_back({exp_rd, exp_err});
        for (int n = 1; n <= 10 && lat == 0; n++) begin
            @(negedge clk);
            if (n == 1) begin
                // Request changes after acceptance must be ignored.
                wr_rdn = ~wr; addr = a ^ 8'h01; wdata = ~d;
            end
            if (ack) lat = n;
        end
        check({tag, "_latency"}, lat, 3);
        e = sb.pop_front();
        if (lat != 0) begin
            check({tag, "_rdata"}, rdata, e[8:1]);
            check({tag, "_err"}, err, e[0]);
        end
        we = 1'b0;
        set_in[5*8 +: 8] = set_at_ack;
        ena = !drop_ena;
        @(negedge clk);
        set_in = '0;
        ena = 1'b1;
    endtask

    initial begin
        int seen;
        rst = 1'b1; ena = 1'b1; we = 1'b0; wr_rdn = 1'b0; addr = '0; wdata = '0;
        status_in = 64'hE7_00_12_34_56_78_9A_BC;
        set_in = '0;
        for (int i = 0; i < 5; i++) m_rw[i] = 8'h5A;
        m_w1c = 8'h00;

        // Reset values
        #1;
        check("rst_ack", ack, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_rdata", rdata, 8'h00);
        check("rst_irq", irq, 1'b0);
        check("rst_reg_out", reg_out, exp_out());
        @(negedge clk);
        rst = 1'b0;

        // 1: read RW reset value
        req("rd3", 1'b0, 8'd3, 8'h00, 8'h5A, 1'b0, 8'h00, 1'b0);
        check("slice3", reg_out[3*8 +: 8], 8'h5A);

        // 2: write then read back
        req("wr2", 1'b1, 8'd2, 8'hA5, 8'h5A, 1'b0, 8'h00, 1'b0);
        m_rw[2] = 8'hA5;
        check("slice2", reg_out[2*8 +: 8], 8'hA5);
        req("rd2", 1'b0, 8'd2, 8'h00, 8'hA5, 1'b0, 8'h00, 1'b0);

        // 3: read-only register
        status_in[6*8 +: 8] = 8'h3C;
        req("rd6", 1'b0, 8'd6, 8'h00, 8'h3C, 1'b0, 8'h00, 1'b0);
        req("wr6", 1'b1, 8'd6, 8'hFF, 8'h3C, 1'b1, 8'h00, 1'b0);
        status_in[6*8 +: 8] = 8'h11;
        #1;
        check("slice6_tracks", reg_out[6*8 +: 8], 8'h11);

        // 4: out-of-range accesses
        req("rd9", 1'b0, 8'd9, 8'h00, 8'h00, 1'b1, 8'h00, 1'b0);
        req("wr8", 1'b1, 8'd8, 8'hC3, 8'h00, 1'b1, 8'h00, 1'b0);
        check("oob_no_change", reg_out, exp_out());

        // 5: write-1-to-clear register
        @(negedge clk);
        set_in[5*8 +: 8] = 8'h81;
        @(negedge clk);
        set_in = '0;
        m_w1c = 8'h81;
        check("w1c_set", reg_out[5*8 +: 8], 8'h81);
        check("w1c_irq_set", irq, 1'b1);
        req("w1c_clr01", 1'b1, 8'd5, 8'h01, 8'h00, 1'b0, 8'h00, 1'b0);
        m_w1c = 8'h80;
        check("w1c_after01", reg_out[5*8 +: 8], 8'h80);
        check("w1c_irq_after01", irq, 1'b1);
        req("w1c_set_wins", 1'b1, 8'd5, 8'h80, 8'h00, 1'b0, 8'h80, 1'b0);
        check("w1c_set_wins_val", reg_out[5*8 +: 8], 8'h80);
        req("w1c_clr80", 1'b1, 8'd5, 8'h80, 8'h00, 1'b0, 8'h00, 1'b0);
        m_w1c = 8'h00;
        check("w1c_cleared", reg_out[5*8 +: 8], 8'h00);
        check("w1c_irq_clear", irq, 1'b0);

        // ena dropped in the ACK cycle: ack stands, write is dropped
        req("wr4_drop_ack", 1'b1, 8'd4, 8'h77, 8'h00, 1'b0, 8'h00, 1'b1);
        check("slice4_kept", reg_out[4*8 +: 8], 8'h5A);

        // 6: abort during WAIT
        @(negedge clk);
        wr_rdn = 1'b1; addr = 8'd1; wdata = 8'h33; we = 1'b1;
        @(negedge clk);
        ena = 1'b0; we = 1'b0;
        seen = 0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            if (ack) seen++;
        end
        ena = 1'b1;
        check("abort_no_ack", seen, 0);
        check("abort_slice1", reg_out[1*8 +: 8], 8'h5A);
        req("rd1_after_abort", 1'b0, 8'd1, 8'h00, 8'h5A, 1'b0, 8'h00, 1'b0);

        // Asynchronous reset in the middle of WAIT
        @(negedge clk);
        set_in[5*8 +: 8] = 8'h04;
        @(negedge clk);
        set_in = '0;
        check("irq_before_rst", irq, 1'b1);
        wr_rdn = 1'b0; addr = 8'd2; we = 1'b1;
        @(negedge clk);
        we = 1'b0;
        #2 rst = 1'b1;
        #1;
        m_rw[2] = 8'h5A;
        m_w1c = 8'h00;
        check("arst_ack", ack, 1'b0);
        check("arst_err", err, 1'b0);
        check("arst_rdata", rdata, 8'h00);
        check("arst_irq", irq, 1'b0);
        check("arst_reg_out", reg_out, exp_out());
        @(negedge clk);
        rst = 1'b0;
        req("rd2_after_rst", 1'b0, 8'd2, 8'h00, 8'h5A, 1'b0, 8'h00, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
